// File: rtl/lpc_coef_sequencer.sv
// Coefficient register-file sequencer: ascending one-hot fill, one-hot replay sweep.
// Define LPC_SEQ_REVERSE_EN to replay from the top index down (time-reversed order).
`timescale 1ns/1ps
module lpc_coef_sequencer #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             start,
    input  logic             reload,
    output logic [DEPTH-1:0] wsel,
    output logic [WIDTH-1:0] wdata,
    output logic [DEPTH-1:0] rsel,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             full,
    output logic [3:0]       fill_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t     W_LAST   = ptr_t'(DEPTH - 1);
    localparam logic [3:0] FILL_MAX = 4'(DEPTH);

`ifdef LPC_SEQ_REVERSE_EN
    localparam ptr_t R_FIRST = ptr_t'(DEPTH - 1);
    localparam ptr_t R_LAST  = '0;
`else
    localparam ptr_t R_FIRST = '0;
    localparam ptr_t R_LAST  = ptr_t'(DEPTH - 1);
`endif

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    ptr_t       wptr_q, wptr_d;
    ptr_t       rptr_q, rptr_d;
    logic [3:0] fill_q, fill_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs are forced idle while reset is held, before the registers clear.
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        fill_d    = fill_q;
        in_ready  = 1'b0;
        wsel      = '0;
        wdata     = in_data;
        rsel      = '0;
        out_valid = 1'b0;
        out_data  = rdata;
        out_last  = 1'b0;
        full      = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FILL: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        wsel = DEPTH'(1) << wptr_q;
                        if (fill_q != FILL_MAX) begin
                            fill_d = fill_q + 4'd1;
                        end
                        if (wptr_q == W_LAST) begin
                            wptr_d  = '0;
                            state_d = S_FULL;
                        end else begin
                            wptr_d = wptr_q + ptr_t'(1);
                        end
                    end
                end
                S_FULL: begin
                    full = 1'b1;
                    if (start) begin
                        rptr_d  = R_FIRST;
                        state_d = S_DRAIN;
                    end else if (reload) begin
                        fill_d  = '0;
                        wptr_d  = '0;
                        state_d = S_FILL;
                    end
                end
                S_DRAIN: begin
                    rsel      = DEPTH'(1) << rptr_q;
                    out_valid = 1'b1;
                    out_last  = (rptr_q == R_LAST);
                    if (out_ready) begin
                        if (rptr_q == R_LAST) begin
                            state_d = S_FULL;
                        end else begin
`ifdef LPC_SEQ_REVERSE_EN
                            rptr_d = rptr_q - ptr_t'(1);
`else
                            rptr_d = rptr_q + ptr_t'(1);
`endif
                        end
                    end
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    assign fill_count = reset ? 4'd0 : fill_q;

endmodule

// File: tb/tb_lpc_coef_sequencer.sv
// Directed bench for lpc_coef_sequencer with a behavioural register file and replay scoreboard.
`timescale 1ns/1ps
module tb_lpc_coef_sequencer;

    localparam int DEPTH = 9;
    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             start;
    logic             reload;
    logic [DEPTH-1:0] wsel;
    logic [WIDTH-1:0] wdata;
    logic [DEPTH-1:0] rsel;
    logic [WIDTH-1:0] rdata;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             full;
    logic [3:0]       fill_count;

    int unsigned passed;
    int unsigned total;
    int unsigned fails;
    int unsigned hs_count;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    exp_t        q[$];
    logic [31:0] loaded[DEPTH];
    logic [31:0] rf[DEPTH];

    lpc_coef_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start), .reload(reload),
        .wsel(wsel), .wdata(wdata), .rsel(rsel), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .full(full), .fill_count(fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) rf[i] <= '0;
            else if (wsel[i]) rf[i] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsel[i]) rdata = rf[i];
        end
    end

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endfunction

    logic        stall_q = 1'b0;
    logic [31:0] st_rsel;
    logic [31:0] st_data;

    always @(negedge clk) begin
        exp_t e;
        if (stall_q) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_rsel", 32'(rsel), st_rsel);
            chk("stall_data", out_data, st_data);
        end
        stall_q = out_valid && !out_ready;
        st_rsel = 32'(rsel);
        st_data = out_data;
        if (out_valid && out_ready) begin
            hs_count++;
            if (q.size() == 0) begin
                chk("out_unexpected", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("out_rsel", 32'(rsel), 32'd1 << e.idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass();
        int idx;
        for (int k = 0; k < DEPTH; k++) begin
`ifdef LPC_SEQ_REVERSE_EN
            idx = DEPTH - 1 - k;
`else
            idx = k;
`endif
            q.push_back('{loaded[idx], (k == DEPTH - 1), idx});
        end
    endtask

    task automatic wait_drain(output int n);
        n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic fill(input logic [31:0] base, input bit gaps);
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                start    = 1'b1;
                reload   = i[0];
                #1;
                chk("gap_wsel", 32'(wsel), 32'd0);
                chk("gap_fill_count", 32'(fill_count), 32'(i));
                step();
            end
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            start    = gaps;
            reload   = gaps;
            #1;
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            chk("fill_wsel", 32'(wsel), 32'd1 << i);
            chk("fill_wdata", wdata, base + 32'(i));
            chk("fill_count_step", 32'(fill_count), 32'(i));
            loaded[i] = base + 32'(i);
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        reload   = 1'b0;
        #1;
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count_done", 32'(fill_count), 32'd9);
        chk("fill_in_ready_low", 32'(in_ready), 32'd0);
        chk("fill_wsel_idle", 32'(wsel), 32'd0);
    endtask

    task automatic run_pass();
        int n;
        push_pass();
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_drain(n);
        #1;
        chk("drain_cycles", 32'(n), 32'd9);
        chk("drain_back_full", 32'(full), 32'd1);
        chk("drain_idle_valid", 32'(out_valid), 32'd0);
        chk("drain_idle_rsel", 32'(rsel), 32'd0);
    endtask

    initial begin
        int n;
        int k;
        int unsigned hs0;
        passed    = 0;
        total     = 0;
        fails     = 0;
        hs_count  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        start     = 1'b0;
        reload    = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) loaded[i] = '0;

        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_fill_count_pre", 32'(fill_count), 32'd0);
        step();
        step();
        #1;
        chk("rst_in_ready_held", 32'(in_ready), 32'd0);
        chk("rst_wsel", 32'(wsel), 32'd0);
        chk("rst_rsel", 32'(rsel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_fill_count", 32'(fill_count), 32'd0);
        step();
        reset = 1'b0;

        // Plain fill, then a replay with out_ready held high.
        fill(32'h100, 1'b0);
        run_pass();

        // Back-to-back pass started in the first FULL cycle, with backpressure 1,0,0,...
        push_pass();
        hs0       = hs_count;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            out_ready = (k % 3 == 0);
            step();
            k++;
        end
        if (q.size() != 0) begin
            chk("bp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_handshakes", hs_count - hs0, 32'd9);
        chk("bp_back_full", 32'(full), 32'd1);

        // start and reload together: start wins.
        push_pass();
        start  = 1'b1;
        reload = 1'b1;
        step();
        start  = 1'b0;
        reload = 1'b0;
        chk("both_drain_valid", 32'(out_valid), 32'd1);
        wait_drain(n);
        #1;
        chk("both_back_full", 32'(full), 32'd1);
        chk("both_fill_count", 32'(fill_count), 32'd9);

        // Reload alone returns to FILL.
        reload = 1'b1;
        step();
        reload = 1'b0;
        #1;
        chk("reload_fill_count", 32'(fill_count), 32'd0);
        chk("reload_in_ready", 32'(in_ready), 32'd1);
        chk("reload_full", 32'(full), 32'd0);

        // Refill with input gaps and ignored commands.
        fill(32'h300, 1'b1);
        run_pass();

        // Reset during the 5th drain word.
        push_pass();
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_remaining", 32'(q.size()), 32'd5);
        q.delete();
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_rsel", 32'(rsel), 32'd0);
        chk("post_rst_full", 32'(full), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_fill_count", 32'(fill_count), 32'd0);
        fill(32'h200, 1'b0);
        run_pass();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
